tcp_stream_slot_manager: RTL and testbench
==========================================

// Module: tcp_stream_slot_manager
// PURPOSE
//  Per-stream TCP reordering controller; parametrised successor of the fixed 4-slot stream record.
//  Holds per-stream, per-direction state in internal registers: expected seq and out-of-order slots (seq/len/dir/valid).
//  Classifies each TCP segment descriptor from the header parser into a command: pass / write / read / drop.
//  The downstream payload buffer executes the command. Buffered slots are drained in order once the gap fills.
// PARAMETERS
//  NUM_STREAMS   16       stream records; stream index width SW = $clog2(NUM_STREAMS)
//  NUM_SLOTS     4        out-of-order slots per stream, shared by both dirs; slot index width LW = $clog2(NUM_SLOTS)
//  LEN_W         16       segment length width
//  WINDOW        65535    max forward distance (seq - exp) accepted into a slot
// PORTS
//  clk           in   1      clock
//  rst_n         in   1      synchronous active-low reset
//  init_done     out  1      record clear sweep finished
//  seg_valid     in   1      segment descriptor valid
//  seg_ready     out  1      descriptor accepted when valid&ready
//  seg_stream    in   SW     stream record index (from hash stage)
//  seg_dir       in   1      direction 0/1
//  seg_syn       in   1      SYN flag
//  seg_seq       in   32     TCP sequence number
//  seg_len       in   LEN_W  payload length, bytes
//  cmd_valid     out  1      command valid
//  cmd_ready     in   1      command consumed when valid&ready
//  cmd_op        out  2      0 pass, 1 write_slot, 2 read_slot, 3 drop
//  cmd_stream    out  SW     stream index
//  cmd_slot      out  LW     slot (ops 1,2; else 0)
//  cmd_dir       out  1      direction
//  cmd_len       out  LEN_W  bytes
//  drop_cnt      out  32     dropped segments, saturating
// BEHAVIOUR
//  Reset: synchronous, active-low.
//   - Outputs on reset: cmd_valid=0, seg_ready=0, init_done=0, drop_cnt=0, cmd_* fields=0.
//   - FSM enters INIT.
//   - Reset mid-operation abandons any pending command; no partial record update is kept.
//  FSM states:
//   - INIT: one record per cycle: exp_valid[2]=0, exp[2]=0, all slot valid=0.
//     After NUM_STREAMS cycles -> IDLE; init_done=1 from then on.
//   - IDLE: seg_ready=1. On accept latch the descriptor -> LOOKUP. Only one segment is in flight.
//   - LOOKUP: read the record -> DECIDE.
//   - DECIDE: register the command; cmd_valid=1 exactly 2 cycles after the accept edge -> EMIT.
//   - EMIT: hold cmd_* stable until cmd_ready, and commit the record update on that handshake.
//     Then go to DRAIN if exp advanced, else IDLE.
//   - DRAIN: scan slots for the lowest index with valid, dir==seg_dir and seq==exp[dir].
//     Hit: op=2, that slot/len; on handshake free the slot, exp+=len, stay in DRAIN.
//     Miss: -> IDLE (one cycle).
//  Decision rules, in priority order (d = seg_seq - exp[dir], 32-bit modulo, signed compare):
//   1. seg_syn: exp[dir]=seg_seq+1; exp_valid[dir]=1; free all slots of dir; op=0.
//   2. !exp_valid[dir] or seg_len==0: op=0, no update.
//   3. d==0: op=0; exp[dir]+=seg_len; enter DRAIN.
//   4. 0<d<=WINDOW and a free slot exists: op=1, lowest free slot; record seq/len/dir, valid=1.
//   5. Otherwise op=3 (old/retransmit d<0, beyond window, or slots full); drop_cnt+=1, saturating at 2^32-1.
//  Arithmetic:
//   - All seq math is mod 2^32; wrap across 0xFFFFFFFF is legal.
//   - A duplicate seq already held in a slot of the same dir is dropped, not re-stored.
//   - cmd_ready low holds state indefinitely; seg_ready=0 outside IDLE.
// TESTING
//  1. Reset release: seg_ready=0 for 16 cycles, then init_done=1. A segment sent before init_done is not accepted.
//  2. SYN seq=1000, dir0 -> op0. Then seq=1001 len=100 -> op0, and exp=1101.
//     cmd_valid rises 2 cycles after accept.
//  3. After SYN 1000: seq=1201 len=50 -> op1 slot0. Then seq=1101 len=100 -> op0.
//     Then drain -> op2 slot0 len50; exp=1251. Slot0 is freed.
//  4. Wrap: SYN seq=0xFFFFFF00; seq=0xFFFFFF01 len=0x200 -> op0, exp=0x00000101.
//     Then seq=0xFFFFFFF0 -> op3, drop_cnt=1.
//  5. Five out-of-order segments, exp=1101: seq 1301/1401/1501/1601 fill slots 0-3.
//     Fifth (1701) -> op3. Hold cmd_ready=0 for 10 cycles: cmd_* stable.
//  6. Assert rst_n=0 during DRAIN: cmd_valid=0 next cycle, INIT resweeps all records.
//     An old-stream segment afterwards -> op0 (exp invalid).

Source files
------------

// File: rtl/tcp_stream_slot_manager.sv
// Per-stream TCP reordering controller: classifies segments into
// pass/write/read/drop commands and drains buffered slots in order.
module tcp_stream_slot_manager #(
  parameter int NUM_STREAMS = 16,
  parameter int NUM_SLOTS   = 4,
  parameter int LEN_W       = 16,
  parameter int WINDOW      = 65535,
  localparam int SW = $clog2(NUM_STREAMS),
  localparam int LW = $clog2(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             init_done,
  input  logic             seg_valid,
  output logic             seg_ready,
  input  logic [SW-1:0]    seg_stream,
  input  logic             seg_dir,
  input  logic             seg_syn,
  input  logic [31:0]      seg_seq,
  input  logic [LEN_W-1:0] seg_len,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [1:0]       cmd_op,
  output logic [SW-1:0]    cmd_stream,
  output logic [LW-1:0]    cmd_slot,
  output logic             cmd_dir,
  output logic [LEN_W-1:0] cmd_len,
  output logic [31:0]      drop_cnt
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_DECIDE, S_EMIT, S_DRAIN
  } state_t;

  typedef enum logic [2:0] {
    U_NONE, U_SYN, U_ADV, U_STORE, U_DROP, U_READ
  } upd_t;

  localparam logic [1:0] OP_PASS  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_DROP  = 2'd3;

  state_t state_q, state_d;
  upd_t   upd_q, dec_upd;

  logic [SW-1:0]    init_idx;
  logic             init_done_q;
  logic [SW-1:0]    in_stream;
  logic             in_dir;
  logic             in_syn;
  logic [31:0]      in_seq;
  logic [LEN_W-1:0] in_len;
  logic [31:0]      r_exp;
  logic             r_expv;
  logic [31:0]      nexp_q;
  logic [31:0]      drop_q;

  logic [1:0]       op_q;
  logic [SW-1:0]    stream_q;
  logic [LW-1:0]    slot_q;
  logic             dir_q;
  logic [LEN_W-1:0] len_q;

  logic [31:0]      exp_q  [NUM_STREAMS][2];
  logic             expv_q [NUM_STREAMS][2];
  logic [31:0]      sl_seq [NUM_STREAMS][NUM_SLOTS];
  logic [LEN_W-1:0] sl_len [NUM_STREAMS][NUM_SLOTS];
  logic             sl_dir [NUM_STREAMS][NUM_SLOTS];
  logic             sl_v   [NUM_STREAMS][NUM_SLOTS];

  logic [31:0]   d;
  logic          fwd;
  logic          dup;
  logic          free_hit;
  logic [LW-1:0] free_idx;
  logic [1:0]    dec_op;
  logic [LW-1:0] dec_slot;
  logic [31:0]   dec_nexp;
  logic [31:0]   cur_exp;
  logic          drn_hit;
  logic [LW-1:0] drn_idx;
  logic          hs;

  assign hs = (state_q == S_EMIT) && cmd_ready;

  // Signed distance decides old / in-order / ahead, modulo 2^32
  always_comb begin
    d        = in_seq - r_exp;
    fwd      = !d[31] && (d != 32'd0) && (d <= 32'(WINDOW));
    dup      = 1'b0;
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!sl_v[in_stream][i]) begin
        free_hit = 1'b1;
        free_idx = LW'(i);
      end
      if (sl_v[in_stream][i] && sl_dir[in_stream][i] == in_dir &&
          sl_seq[in_stream][i] == in_seq)
        dup = 1'b1;
    end
    dec_op   = OP_DROP;
    dec_upd  = U_DROP;
    dec_slot = '0;
    dec_nexp = r_exp;
    if (in_syn) begin
      dec_op   = OP_PASS;
      dec_upd  = U_SYN;
      dec_nexp = in_seq + 32'd1;
    end else if (!r_expv || in_len == '0) begin
      dec_op  = OP_PASS;
      dec_upd = U_NONE;
    end else if (d == 32'd0) begin
      dec_op   = OP_PASS;
      dec_upd  = U_ADV;
      dec_nexp = r_exp + 32'(in_len);
    end else if (fwd && free_hit && !dup) begin
      dec_op   = OP_WRITE;
      dec_upd  = U_STORE;
      dec_slot = free_idx;
    end
  end

  always_comb begin
    cur_exp = exp_q[in_stream][in_dir];
    drn_hit = 1'b0;
    drn_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (sl_v[in_stream][i] && sl_dir[in_stream][i] == in_dir &&
          sl_seq[in_stream][i] == cur_exp) begin
        drn_hit = 1'b1;
        drn_idx = LW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:   if (init_idx == SW'(NUM_STREAMS - 1)) state_d = S_IDLE;
      S_IDLE:   if (seg_valid) state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_DECIDE;
      S_DECIDE: state_d = S_EMIT;
      S_EMIT: begin
        if (cmd_ready)
          state_d = (upd_q == U_ADV || upd_q == U_READ) ? S_DRAIN : S_IDLE;
      end
      S_DRAIN:  state_d = drn_hit ? S_EMIT : S_IDLE;
      default:  state_d = S_INIT;
    endcase
  end

  always_comb begin
    seg_ready  = (state_q == S_IDLE);
    cmd_valid  = (state_q == S_EMIT);
    init_done  = init_done_q;
    cmd_op     = op_q;
    cmd_stream = stream_q;
    cmd_slot   = slot_q;
    cmd_dir    = dir_q;
    cmd_len    = len_q;
    drop_cnt   = drop_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_idx    <= '0;
      init_done_q <= 1'b0;
      in_stream   <= '0;
      in_dir      <= 1'b0;
      in_syn      <= 1'b0;
      in_seq      <= '0;
      in_len      <= '0;
      r_exp       <= '0;
      r_expv      <= 1'b0;
      nexp_q      <= '0;
      drop_q      <= '0;
      upd_q       <= U_NONE;
      op_q        <= '0;
      stream_q    <= '0;
      slot_q      <= '0;
      dir_q       <= 1'b0;
      len_q       <= '0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == SW'(NUM_STREAMS - 1)) init_done_q <= 1'b1;
        end
        S_IDLE: begin
          if (seg_valid) begin
            in_stream <= seg_stream;
            in_dir    <= seg_dir;
            in_syn    <= seg_syn;
            in_seq    <= seg_seq;
            in_len    <= seg_len;
          end
        end
        S_LOOKUP: begin
          r_exp  <= exp_q[in_stream][in_dir];
          r_expv <= expv_q[in_stream][in_dir];
        end
        S_DECIDE: begin
          op_q     <= dec_op;
          slot_q   <= dec_slot;
          stream_q <= in_stream;
          dir_q    <= in_dir;
          len_q    <= in_len;
          upd_q    <= dec_upd;
          nexp_q   <= dec_nexp;
        end
        S_EMIT: begin
          if (cmd_ready && upd_q == U_DROP && drop_q != '1)
            drop_q <= drop_q + 32'd1;
        end
        S_DRAIN: begin
          if (drn_hit) begin
            op_q   <= OP_READ;
            slot_q <= drn_idx;
            len_q  <= sl_len[in_stream][drn_idx];
            nexp_q <= cur_exp + 32'(sl_len[in_stream][drn_idx]);
            upd_q  <= U_READ;
          end
        end
        default: ;
      endcase
    end
  end

  // Record store: cleared by the INIT sweep, updated only on a handshake
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == S_INIT) begin
        for (int k = 0; k < 2; k++) begin
          exp_q[init_idx][k]  <= '0;
          expv_q[init_idx][k] <= 1'b0;
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
          sl_seq[init_idx][i] <= '0;
          sl_len[init_idx][i] <= '0;
          sl_dir[init_idx][i] <= 1'b0;
          sl_v[init_idx][i]   <= 1'b0;
        end
      end else if (hs) begin
        unique case (upd_q)
          U_SYN: begin
            exp_q[in_stream][in_dir]  <= nexp_q;
            expv_q[in_stream][in_dir] <= 1'b1;
            for (int i = 0; i < NUM_SLOTS; i++)
              if (sl_dir[in_stream][i] == in_dir)
                sl_v[in_stream][i] <= 1'b0;
          end
          U_ADV: exp_q[in_stream][in_dir] <= nexp_q;
          U_STORE: begin
            sl_seq[in_stream][slot_q] <= in_seq;
            sl_len[in_stream][slot_q] <= in_len;
            sl_dir[in_stream][slot_q] <= in_dir;
            sl_v[in_stream][slot_q]   <= 1'b1;
          end
          U_READ: begin
            exp_q[in_stream][in_dir] <= nexp_q;
            sl_v[in_stream][slot_q]  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tcp_stream_slot_manager.sv
// Directed bench for tcp_stream_slot_manager with hand-computed
// expected commands, latencies and drop counts.
module tb_tcp_stream_slot_manager;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic        seg_valid;
  logic        seg_ready;
  logic [3:0]  seg_stream;
  logic        seg_dir;
  logic        seg_syn;
  logic [31:0] seg_seq;
  logic [15:0] seg_len;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_stream;
  logic [1:0]  cmd_slot;
  logic        cmd_dir;
  logic [15:0] cmd_len;
  logic [31:0] drop_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tcp_stream_slot_manager dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_done  (init_done),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .seg_stream (seg_stream),
    .seg_dir    (seg_dir),
    .seg_syn    (seg_syn),
    .seg_seq    (seg_seq),
    .seg_len    (seg_len),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_stream (cmd_stream),
    .cmd_slot   (cmd_slot),
    .cmd_dir    (cmd_dir),
    .cmd_len    (cmd_len),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic take(input string tag, input logic [3:0] st,
                      input logic dir, input logic [1:0] op,
                      input logic [1:0] slot, input logic [15:0] len,
                      input int hold);
    chk({tag, "_op"}, cmd_op, op);
    chk({tag, "_slot"}, cmd_slot, slot);
    chk({tag, "_len"}, cmd_len, len);
    chk({tag, "_st"}, cmd_stream, st);
    chk({tag, "_dir"}, cmd_dir, dir);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk({tag, "_hold_v"}, cmd_valid, 1);
      chk({tag, "_hold_op"}, cmd_op, op);
      chk({tag, "_hold_slot"}, cmd_slot, slot);
      chk({tag, "_hold_len"}, cmd_len, len);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  task automatic send(input string tag, input logic [3:0] st,
                      input logic dir, input logic syn,
                      input logic [31:0] seq, input logic [15:0] len,
                      input logic [1:0] op, input logic [1:0] slot,
                      input int hold);
    int w = 0;
    int lat = 0;
    while (!seg_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!seg_ready) begin
      chk({tag, "_ready_timeout"}, 0, 1);
      return;
    end
    seg_stream = st;
    seg_dir    = dir;
    seg_syn    = syn;
    seg_seq    = seq;
    seg_len    = len;
    seg_valid  = 1'b1;
    @(negedge clk);
    seg_valid = 1'b0;
    while (!cmd_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 2);
    if (cmd_valid) take(tag, st, dir, op, slot, len, hold);
  endtask

  task automatic drain(input string tag, input logic [3:0] st,
                       input logic dir, input logic [1:0] slot,
                       input logic [15:0] len);
    int w = 0;
    while (!cmd_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_seen"}, cmd_valid, 1);
    if (cmd_valid) take(tag, st, dir, 2'd2, slot, len, 0);
  endtask

  task automatic wait_init(input string tag);
    int cnt = 0;
    while (!seg_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_init_cycles"}, cnt, 16);
    chk({tag, "_init_done"}, init_done, 1);
  endtask

  initial begin
    int early;
    rst_n      = 1'b0;
    seg_valid  = 1'b0;
    seg_stream = '0;
    seg_dir    = 1'b0;
    seg_syn    = 1'b0;
    seg_seq    = '0;
    seg_len    = '0;
    cmd_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_seg_ready", seg_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_cmd_op", cmd_op, 0);

    // Segment presented before init_done must not be taken
    rst_n      = 1'b1;
    seg_stream = 4'd9;
    seg_seq    = 32'd77;
    seg_len    = 16'd1;
    seg_valid  = 1'b1;
    early = 0;
    begin
      int cnt = 0;
      while (!seg_ready && cnt < 100) begin
        @(negedge clk);
        cnt++;
        if (cmd_valid) early++;
      end
      chk("init_cycles", cnt, 16);
      chk("init_done", init_done, 1);
    end
    seg_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_early_cmd", early + int'(cmd_valid), 0);

    send("t2_syn", 4'd1, 0, 1, 32'd1000, 16'd0, 2'd0, 2'd0, 0);
    send("t2_inord", 4'd1, 0, 0, 32'd1001, 16'd100, 2'd0, 2'd0, 0);

    send("t3_ooo", 4'd1, 0, 0, 32'd1201, 16'd50, 2'd1, 2'd0, 0);
    send("t3_fill", 4'd1, 0, 0, 32'd1101, 16'd100, 2'd0, 2'd0, 0);
    drain("t3_drain", 4'd1, 0, 2'd0, 16'd50);
    send("t3_exp1251", 4'd1, 0, 0, 32'd1251, 16'd5, 2'd0, 2'd0, 0);
    send("t3_slot_free", 4'd1, 0, 0, 32'd1300, 16'd10, 2'd1, 2'd0, 0);

    send("t4_syn", 4'd2, 0, 1, 32'hFFFFFF00, 16'd0, 2'd0, 2'd0, 0);
    send("t4_wrap", 4'd2, 0, 0, 32'hFFFFFF01, 16'h200, 2'd0, 2'd0, 0);
    send("t4_old", 4'd2, 0, 0, 32'hFFFFFFF0, 16'd16, 2'd3, 2'd0, 0);
    chk("t4_drop_cnt", drop_cnt, 1);
    send("t4_exp101", 4'd2, 0, 0, 32'h00000101, 16'd1, 2'd0, 2'd0, 0);

    send("t5_syn", 4'd3, 0, 1, 32'd1000, 16'd0, 2'd0, 2'd0, 0);
    send("t5_inord", 4'd3, 0, 0, 32'd1001, 16'd100, 2'd0, 2'd0, 0);
    send("t5_s0", 4'd3, 0, 0, 32'd1301, 16'd10, 2'd1, 2'd0, 0);
    send("t5_s1", 4'd3, 0, 0, 32'd1401, 16'd10, 2'd1, 2'd1, 0);
    send("t5_s2", 4'd3, 0, 0, 32'd1501, 16'd10, 2'd1, 2'd2, 0);
    send("t5_s3", 4'd3, 0, 0, 32'd1601, 16'd10, 2'd1, 2'd3, 0);
    send("t5_full", 4'd3, 0, 0, 32'd1701, 16'd10, 2'd3, 2'd0, 10);
    chk("t5_drop_cnt", drop_cnt, 2);

    send("dup_syn", 4'd4, 0, 1, 32'd0, 16'd0, 2'd0, 2'd0, 0);
    send("dup_first", 4'd4, 0, 0, 32'd50, 16'd5, 2'd1, 2'd0, 0);
    send("dup_again", 4'd4, 0, 0, 32'd50, 16'd5, 2'd3, 2'd0, 0);
    send("win_edge", 4'd4, 0, 0, 32'd65536, 16'd1, 2'd1, 2'd1, 0);
    send("win_over", 4'd4, 0, 0, 32'd65537, 16'd1, 2'd3, 2'd0, 0);
    send("len0", 4'd4, 0, 0, 32'd99, 16'd0, 2'd0, 2'd0, 0);
    send("dir1_noexp", 4'd4, 1, 0, 32'd7, 16'd3, 2'd0, 2'd0, 0);
    chk("drop_cnt_4", drop_cnt, 4);

    send("t6_syn", 4'd5, 0, 1, 32'd1000, 16'd0, 2'd0, 2'd0, 0);
    send("t6_ooo", 4'd5, 0, 0, 32'd1101, 16'd10, 2'd1, 2'd0, 0);
    send("t6_fill", 4'd5, 0, 0, 32'd1001, 16'd100, 2'd0, 2'd0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_cmd_valid", cmd_valid, 0);
    chk("t6_rst_drop", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("t6");
    send("t6_old_stream", 4'd1, 0, 0, 32'd5000, 16'd10, 2'd0, 2'd0, 0);
    send("t6_s5_cleared", 4'd5, 0, 0, 32'd1101, 16'd10, 2'd0, 2'd0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
